// File: rtl/toeplitz_hash_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// toeplitz_hash_ctrl
//
// Privacy-amplification sequencer. It drains 32-bit raw-key words from the
// upstream FIFO and compresses each block of BLK_WORDS words into an OUT_W-bit
// Toeplitz hash. The hash is computed by a bit-serial multiply-accumulate: for
// every input bit that is 1, an OUT_W-bit window of the stored seed is XORed
// into the accumulator. Each result is offered downstream on a valid/ready
// handshake.
//
// Ports
//   clk_in       system clock, rising edge
//   rst          asynchronous active-high reset
//   enable       permits starting a new block (sampled in IDLE and DONE)
//   seed_wr      seed word write strobe (accepted in IDLE only)
//   seed_data    seed word, written at the internal seed pointer
//   seed_loaded  all SEED_WORDS seed words are present
//   fifo_empty   upstream FIFO empty flag
//   fifo_rd_en   FIFO pop; data appears on fifo_dout the following cycle
//   fifo_dout    FIFO read data
//   hash_out     hash result (accumulator contents)
//   hash_valid   hash_out holds a finished hash
//   hash_ready   downstream accepts the hash
//   busy         sequencer is not idle
//   blk_count    number of hashes delivered, wraps at 16 bits
//
// OUT_W must be a multiple of 32.
// -----------------------------------------------------------------------------
module toeplitz_hash_ctrl #(
  parameter int BLK_WORDS = 8,
  parameter int OUT_W     = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             seed_wr,
  input  logic [31:0]      seed_data,
  output logic             seed_loaded,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [31:0]      fifo_dout,
  output logic [OUT_W-1:0] hash_out,
  output logic             hash_valid,
  input  logic             hash_ready,
  output logic             busy,
  output logic [15:0]      blk_count
);

  localparam int SEED_WORDS = BLK_WORDS + OUT_W / 32;
  localparam int N          = 32 * BLK_WORDS;
  localparam int SEED_BITS  = 32 * SEED_WORDS;
  localparam int PW         = $clog2(SEED_BITS);
  localparam int SPW        = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;
  localparam int WCW        = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SEED_BITS-1:0] seed_q, seed_d;
  logic [SPW-1:0]       seed_ptr_q, seed_ptr_d;
  logic                 seed_loaded_q, seed_loaded_d;
  logic [31:0]          word_q, word_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]       word_cnt_q, word_cnt_d;
  logic [OUT_W-1:0]     acc_q, acc_d;
  logic [15:0]          blk_count_q, blk_count_d;

  logic                 last_bit;
  logic                 last_word;
  logic [PW-1:0]        win_pos;
  logic [OUT_W-1:0]     seed_window;

  // The input bit index is c = 32*word_cnt + bit_cnt, which is simply the
  // concatenation of the two counters. Its seed window starts at s[N-1-c],
  // so the window slides down the seed by one bit per processed input bit.
  assign win_pos     = PW'(N - 1) - PW'({word_cnt_q, bit_cnt_q});
  assign seed_window = seed_q[win_pos +: OUT_W];
  assign last_bit    = (bit_cnt_q == 5'd31);
  assign last_word   = (word_cnt_q == WCW'(BLK_WORDS - 1));

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A FIFO stall in REQ and back-pressure in DONE both
  // simply hold the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A seed write in the same cycle wins; the block starts afterwards.
        if (enable && seed_loaded_q && !seed_wr) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!fifo_empty) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = last_word ? ST_DONE : ST_REQ;
        end
      end
      ST_DONE: begin
        if (hash_ready) begin
          state_d = enable ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic. The FIFO pop is combinational so that a word requested in
  // REQ is on fifo_dout exactly when WAIT latches it.
  always_comb begin
    fifo_rd_en = 1'b0;
    hash_valid = 1'b0;
    busy       = 1'b1;
    case (state_q)
      ST_IDLE: busy       = 1'b0;
      ST_REQ:  fifo_rd_en = !fifo_empty;
      ST_DONE: hash_valid = 1'b1;
      default: ;
    endcase
  end

  assign hash_out    = acc_q;
  assign seed_loaded = seed_loaded_q;
  assign blk_count   = blk_count_q;

  // Datapath next values: seed loading, word capture, the serial
  // multiply-accumulate and the end-of-block bookkeeping.
  always_comb begin
    seed_d        = seed_q;
    seed_ptr_d    = seed_ptr_q;
    seed_loaded_d = seed_loaded_q;
    word_d        = word_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    acc_d         = acc_q;
    blk_count_d   = blk_count_q;
    case (state_q)
      ST_IDLE: begin
        if (seed_wr) begin
          if (seed_loaded_q) begin
            // Writing over a complete seed restarts the load at word 0.
            seed_d[31:0]  = seed_data;
            seed_ptr_d    = SPW'(1);
            seed_loaded_d = 1'b0;
          end else begin
            seed_d[{seed_ptr_q, 5'b00000} +: 32] = seed_data;
            if (seed_ptr_q == SPW'(SEED_WORDS - 1)) begin
              seed_ptr_d    = '0;
              seed_loaded_d = 1'b1;
            end else begin
              seed_ptr_d = seed_ptr_q + 1'b1;
            end
          end
        end
      end
      ST_WAIT: begin
        word_d    = fifo_dout;
        bit_cnt_d = '0;
      end
      ST_SHIFT: begin
        if (word_q[bit_cnt_q]) begin
          acc_d = acc_q ^ seed_window;
        end
        bit_cnt_d = bit_cnt_q + 5'd1;
        // The word counter parks on the last word until the hash is taken.
        if (last_bit && !last_word) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (hash_ready) begin
          blk_count_d = blk_count_q + 16'd1;
          acc_d       = '0;
          word_cnt_d  = '0;
          bit_cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      seed_q        <= '0;
      seed_ptr_q    <= '0;
      seed_loaded_q <= 1'b0;
      word_q        <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      acc_q         <= '0;
      blk_count_q   <= '0;
    end else begin
      seed_q        <= seed_d;
      seed_ptr_q    <= seed_ptr_d;
      seed_loaded_q <= seed_loaded_d;
      word_q        <= word_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      acc_q         <= acc_d;
      blk_count_q   <= blk_count_d;
    end
  end

endmodule

// File: doc/toeplitz_hash_ctrl.md
Name: toeplitz_hash_ctrl

Overview:
Sequencer that drains 32-bit raw-key words from the upstream FIFO and compresses each block of BLK_WORDS words into an OUT_W-bit Toeplitz hash (privacy amplification). It holds the Toeplitz seed, pops the FIFO one word at a time, and runs a bit-serial multiply-accumulate over each word. It presents each result through a valid/ready handshake. It sits between the FIFO inside total_module and the key output stage.

Parameters:
BLK_WORDS, 8, input words per hash block; N = 32*BLK_WORDS input bits
OUT_W, 32, hash width in bits; must be a multiple of 32
SEED_WORDS, BLK_WORDS+OUT_W/32, seed words loaded, derived (not overridden)

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  permits starting a new block
seed_wr  input  1  seed word write strobe
seed_data  input  32  seed word
seed_loaded  output  1  full seed present
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO pop; data valid on fifo_dout the next cycle
fifo_dout  input  32  FIFO read data
hash_out  output  OUT_W  hash result
hash_valid  output  1  hash_out valid
hash_ready  input  1  downstream accepts hash
busy  output  1  state is not IDLE
blk_count  output  16  blocks delivered, wraps 0xFFFF->0

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0; accumulator, seed, seed pointer, bit and word counters cleared; seed_loaded=0.
- Bit numbering: x[c], c=0..N-1, with c = 32*word_index + bit, bit 0 = LSB of the first popped word. Seed bit s[k] = bit k%32 of seed word k/32. Words are loaded in index order from 0. Bit s[SEED_WORDS*32-1] is unused.
- Hash definition: h[r] = XOR over c of (x[c] AND s[r-c+N-1]), r=0..OUT_W-1. hash_out[r]=h[r].
- Seed load is accepted only in IDLE. Each seed_wr writes word seed_ptr, then seed_ptr increments. seed_loaded rises on the cycle after the write of word SEED_WORDS-1. A seed_wr while seed_loaded=1 clears seed_loaded and writes index 0. seed_wr outside IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, SHIFT, DONE.
- IDLE: go to REQ when enable=1 and seed_loaded=1 and seed_wr=0.
- REQ: fifo_rd_en = !fifo_empty. This is a combinational output, asserted only in REQ. If popped, go to WAIT. Otherwise stay in REQ; a stall of any length is legal.
- WAIT: latch fifo_dout into the word register, clear bit_cnt, go to SHIFT.
- SHIFT: one input bit per cycle, LSB first. If the bit is 1, acc ^= the OUT_W-bit seed window starting at s[N-1-c]. bit_cnt counts 0..31. After bit 31: if word_cnt = BLK_WORDS-1, go to DONE; otherwise increment word_cnt and go to REQ.
- DONE: hash_valid=1 and hash_out=acc, both held stable while hash_ready=0. When hash_valid and hash_ready are both high: blk_count increments, acc and counters clear, and the next state is REQ if enable=1, otherwise IDLE. hash_valid drops the next cycle.
- Latency with a non-empty FIFO: 34 cycles per word. hash_valid asserts 34*BLK_WORDS cycles after the first REQ cycle (272 at defaults).
- enable is sampled only in IDLE and DONE. Deasserting it mid-block lets the current block complete.
- busy = (state != IDLE).
- The seed is reused unchanged for every block.
- fifo_rd_en is never asserted while fifo_empty=1.

Test Plan:
- Seed all-ones (BLK_WORDS=1, OUT_W=32, SEED_WORDS=2); push 0x00000001 -> hash_out=0xFFFFFFFF, hash_valid at cycle 34 after the first REQ cycle, blk_count=1.
- BLK_WORDS=1, seed with only s[31]=1: input 0x00000001 -> 0x00000001. Input 0x80000000 -> 0x80000000. Input 0x00000000 -> 0x00000000.
- Defaults, random seed: push 8 random words a, then b, then a^b -> hash(a^b) == hash(a)^hash(b). Every hash matches the C reference model of the hash definition.
- fifo_empty held high for 10 cycles in REQ mid-block -> fifo_rd_en=0 throughout, no state change, hash_valid delayed by exactly 10 cycles (282 total).
- hash_ready held low for 5 cycles in DONE -> hash_valid and hash_out held stable, no FIFO pops, no blk_count change. Then hash_ready=1 -> blk_count increments once.
- Assert rst during SHIFT of word 3 -> all outputs 0 immediately, seed_loaded=0. With enable=1 there is no FIFO pop until a full seed reload, and seed_wr during SHIFT (pre-reset) had no effect.
